// File: rtl/msx_audio_post.sv
// msx_audio_post: box decimator, one-pole IIR low-pass and registered 16-bit output with valid strobe.
// Define MSX_AUDIO_DCBLOCK_EN to add the saturating DC-blocking high-pass in the output stage.
module msx_audio_post #(
    parameter int unsigned LOG2_DECIM = 6,
    parameter int unsigned SHIFT_LP   = 3,
    parameter int unsigned SHIFT_DC   = 10
) (
    input  logic        clk21m,
    input  logic        reset_n,
    input  logic        ce_3m58_p,
    input  logic [15:0] audio_in,
    input  logic        mute,
    output logic [15:0] audio_out,
    output logic        audio_valid,
    output logic        clip
);
    localparam int unsigned ACC_W = 16 + LOG2_DECIM;
    localparam int unsigned Y_W   = 24;
    localparam int unsigned YE_W  = 25;

    if (LOG2_DECIM < 1 || LOG2_DECIM > 8 || SHIFT_LP < 1 || SHIFT_LP > 7 ||
        SHIFT_DC < 1 || SHIFT_DC > 16) begin : g_param_check
        $error("msx_audio_post: parameter out of legal range");
    end

    logic [LOG2_DECIM-1:0]   cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [15:0]      avg;
    logic signed [Y_W-1:0]   y;
    logic                    stb1;
    logic                    stb2;

    logic signed [15:0]      x_c;
    logic signed [ACC_W-1:0] acc_sum_c;
    logic signed [YE_W-1:0]  y_err_c;
    logic signed [YE_W-1:0]  y_next_c;
    logic signed [15:0]      y_hi_c;
    logic [15:0]             out_c;
    logic                    sat_c;

    // Decimator input: the wrap sample is folded into the finished block's sum
    always_comb begin
        x_c       = mute ? '0 : signed'(audio_in);
        acc_sum_c = acc + ACC_W'(x_c);
    end

    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            acc  <= '0;
            avg  <= '0;
            stb1 <= 1'b0;
        end else begin
            stb1 <= 1'b0;
            if (ce_3m58_p) begin
                if (&cnt) begin
                    avg  <= 16'(acc_sum_c >>> LOG2_DECIM);
                    acc  <= '0;
                    cnt  <= '0;
                    stb1 <= 1'b1;
                end else begin
                    acc <= acc_sum_c;
                    cnt <= cnt + LOG2_DECIM'(1);
                end
            end
        end
    end

    // One-pole low-pass: y moves 2^-SHIFT_LP of the way toward avg each sample
    always_comb begin
        y_err_c  = YE_W'(signed'({avg, 8'h00})) - YE_W'(y);
        y_next_c = YE_W'(y) + (y_err_c >>> SHIFT_LP);
    end

    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            y    <= '0;
            stb2 <= 1'b0;
        end else begin
            stb2 <= stb1;
            if (stb1) begin
                y <= Y_W'(y_next_c);
            end
        end
    end

`ifdef MSX_AUDIO_DCBLOCK_EN
    localparam int unsigned DC_W = 26;
    localparam int unsigned DE_W = 27;
    localparam int unsigned D_W  = 17;

    logic signed [DC_W-1:0] dc;
    logic signed [D_W-1:0]  d_c;
    logic signed [DE_W-1:0] dc_err_c;
    logic signed [DE_W-1:0] dc_next_c;

    // Output stage: subtract the slow DC estimate and clamp to 16 bits
    always_comb begin
        y_hi_c    = signed'(y[Y_W-1:8]);
        d_c       = D_W'(y_hi_c) - D_W'(signed'(dc[DC_W-1:DC_W-16]));
        dc_err_c  = DE_W'(signed'({y_hi_c, 10'b0})) - DE_W'(dc);
        dc_next_c = DE_W'(dc) + (dc_err_c >>> SHIFT_DC);
        out_c     = d_c[15:0];
        sat_c     = 1'b0;
        if (d_c[16] != d_c[15]) begin
            sat_c = 1'b1;
            out_c = d_c[16] ? 16'h8000 : 16'h7FFF;
        end
    end

    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            dc <= '0;
        end else if (stb2) begin
            dc <= DC_W'(dc_next_c);
        end
    end
`else
    // Output stage: y is already bounded, so no clamping is possible
    always_comb begin
        y_hi_c = signed'(y[Y_W-1:8]);
        out_c  = y_hi_c;
        sat_c  = 1'b0;
    end
`endif

    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            audio_out   <= '0;
            audio_valid <= 1'b0;
            clip        <= 1'b0;
        end else begin
            audio_valid <= stb2;
            if (stb2) begin
                audio_out <= out_c;
                clip      <= clip | sat_c;
            end
        end
    end

endmodule

// File: tb/tb_msx_audio_post.sv
// Scoreboard bench for msx_audio_post: a driver pushes per-block expectations (value and due cycle),
// a monitor pops and compares on every audio_valid strobe.
module tb_msx_audio_post;
    localparam int LOG2_DECIM = 6;
    localparam int SHIFT_LP   = 3;
    localparam int SHIFT_DC   = 10;
    localparam int NBLK       = 1 << LOG2_DECIM;

    logic        clk21m = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_3m58_p = 1'b0;
    logic [15:0] audio_in = 16'h0000;
    logic        mute = 1'b0;
    logic [15:0] audio_out;
    logic        audio_valid;
    logic        clip;

    msx_audio_post #(
        .LOG2_DECIM(LOG2_DECIM),
        .SHIFT_LP  (SHIFT_LP),
        .SHIFT_DC  (SHIFT_DC)
    ) dut (
        .clk21m     (clk21m),
        .reset_n    (reset_n),
        .ce_3m58_p  (ce_3m58_p),
        .audio_in   (audio_in),
        .mute       (mute),
        .audio_out  (audio_out),
        .audio_valid(audio_valid),
        .clip       (clip)
    );

    always #5 clk21m = ~clk21m;

    int cyc = 0;
    always @(posedge clk21m) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] val;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          mono_dir = 0;
    int          mono_viol = 0;
    logic [15:0] prev_out = 16'h0000;
    bit          saw_min = 1'b0;
    bit          cont = 1'b0;
    int          y_m = 0;
    int          dc_m = 0;

    // Monitor: every strobe must match the oldest expectation, in value and in cycle
    always @(negedge clk21m) begin
        exp_t e;
        if (reset_n && audio_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: audio_out=%h at cycle %0d, required no strobe", audio_out, cyc);
            end else begin
                e = sb.pop_front();
                if (audio_out !== e.val || cyc != e.due) begin
                    errors++;
                    $display("FAIL sample: audio_out=%h at cycle %0d, required %h at cycle %0d",
                             audio_out, cyc, e.val, e.due);
                end
            end
            if (mono_dir > 0 && $signed(audio_out) < $signed(prev_out)) mono_viol++;
            if (mono_dir < 0 && $signed(audio_out) > $signed(prev_out)) mono_viol++;
            if (audio_out == 16'h8000) saw_min = 1'b1;
            prev_out = audio_out;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        y_m  = 0;
        dc_m = 0;
    endtask

    // Reference arithmetic on plain integers (>>> on int floors toward -inf)
    task automatic model_block(input int sum, output logic [15:0] o);
        int avg;
        int yh;
        avg = sum >>> LOG2_DECIM;
        y_m = y_m + ((avg * 256 - y_m) >>> SHIFT_LP);
        yh  = y_m >>> 8;
`ifdef MSX_AUDIO_DCBLOCK_EN
        begin
            int d;
            d = yh - (dc_m >>> 10);
            if (d > 32767) d = 32767;
            else if (d < -32768) d = -32768;
            dc_m = dc_m + ((yh * 1024 - dc_m) >>> SHIFT_DC);
            o = 16'(d);
        end
`else
        o = 16'(yh);
`endif
    endtask

    task automatic put(input logic [15:0] v, input logic m, output int t);
        @(posedge clk21m);
        #1;
        ce_3m58_p = 1'b1;
        audio_in  = v;
        mute      = m;
        t         = cyc;
        if (!cont) begin
            @(posedge clk21m);
            #1;
            ce_3m58_p = 1'b0;
        end
    endtask

    // One decimation block: NBLK-1 samples of vf, then the wrap sample vl
    task automatic send_block(input logic [15:0] vf, input logic [15:0] vl, input logic m);
        int          sum;
        int          t;
        logic [15:0] o;
        exp_t        e;
        sum = 0;
        for (int i = 0; i < NBLK - 1; i++) begin
            put(vf, m, t);
            sum += m ? 0 : int'($signed(vf));
        end
        put(vl, m, t);
        sum += m ? 0 : int'($signed(vl));
        model_block(sum, o);
        e.val = o;
        e.due = t + 3;
        sb.push_back(e);
    endtask

    task automatic send_n(input int n, input logic [15:0] v, input logic m);
        for (int i = 0; i < n; i++) send_block(v, v, m);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk21m);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d samples still pending, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk21m);
    endtask

    task automatic do_reset();
        @(posedge clk21m);
        #2;
        reset_n = 1'b0;
        model_reset();
        @(posedge clk21m);
        #1;
        reset_n  = 1'b1;
        prev_out = 16'h0000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        repeat (3) @(posedge clk21m);
        #1;
        check("reset_audio_out", 32'(audio_out), 32'h0);
        check("reset_valid", 32'(audio_valid), 32'h0);
        check("reset_clip", 32'(clip), 32'h0);
        @(posedge clk21m);
        #1;
        reset_n = 1'b1;

        // 63 zeros then 0x4000: avg 0x0100, first IIR output 0x0020
        send_block(16'h0000, 16'h4000, 1'b0);
        drain();
        check("decim_exact", 32'(audio_out), 32'h0020);

        // Reset mid-accumulation clears outputs at once and restarts the block phase
        for (int i = 0; i < 20; i++) put(16'h1234, 1'b0, t);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_audio_out", 32'(audio_out), 32'h0);
        check("midreset_valid", 32'(audio_valid), 32'h0);
        check("midreset_clip", 32'(clip), 32'h0);
        model_reset();
        @(posedge clk21m);
        #1;
        reset_n = 1'b1;

        // Sum of -1 floors to avg -1; output -1
        send_block(16'h0000, 16'hFFFF, 1'b0);
        drain();
        check("floor_negative", 32'(audio_out), 32'h0000FFFF);

        // Constant 0x1000 from zero state: 0x0200, 0x03C0, ... settling at 0x1000
        do_reset();
`ifndef MSX_AUDIO_DCBLOCK_EN
        mono_dir = 1;
`endif
        mono_viol = 0;
        send_block(16'h1000, 16'h1000, 1'b0);
        drain();
        check("const_first", 32'(audio_out), 32'h0200);
        send_block(16'h1000, 16'h1000, 1'b0);
        drain();
        check("const_second", 32'(audio_out), 32'h03C0);
        send_n(78, 16'h1000, 1'b0);
        drain();
`ifndef MSX_AUDIO_DCBLOCK_EN
        check("const_settle", 32'(audio_out >= 16'h0FFF && audio_out <= 16'h1001), 32'h1);
        check("const_monotonic", 32'(mono_viol), 32'h0);
`endif

        // Mute: settle at 0x2000, decay to 0 without overshoot, then recover
        send_n(80, 16'h2000, 1'b0);
        drain();
`ifndef MSX_AUDIO_DCBLOCK_EN
        mono_dir = -1;
`endif
        mono_viol = 0;
        send_n(80, 16'h2000, 1'b1);
        drain();
`ifndef MSX_AUDIO_DCBLOCK_EN
        check("mute_zero", 32'(audio_out), 32'h0);
        check("mute_monotonic", 32'(mono_viol), 32'h0);
        mono_dir = 1;
`endif
        mono_viol = 0;
        send_n(20, 16'h2000, 1'b0);
        drain();
`ifndef MSX_AUDIO_DCBLOCK_EN
        check("unmute_recover", 32'($signed(audio_out) > 16'sh1C00), 32'h1);
        check("unmute_monotonic", 32'(mono_viol), 32'h0);
`endif
        mono_dir = 0;

        // Enable held high continuously: one block every NBLK clocks
        cont = 1'b1;
        send_n(3, 16'h0800, 1'b0);
        @(posedge clk21m);
        #1;
        ce_3m58_p = 1'b0;
        cont = 1'b0;
        drain();

`ifdef MSX_AUDIO_DCBLOCK_EN
        // Positive full scale never clips; a swing to negative full scale does
        do_reset();
        send_n(40, 16'h2000, 1'b0);
        send_n(40, 16'h7FFF, 1'b0);
        drain();
        check("dc_no_clip", 32'(clip), 32'h0);
        saw_min = 1'b0;
        send_n(48, 16'h8000, 1'b0);
        drain();
        check("dc_sat_seen", 32'(saw_min), 32'h1);
        check("dc_clip", 32'(clip), 32'h1);
`else
        check("clip_tied_low", 32'(clip), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
